// File: rtl/dmem_pipe.sv
// Pipelined data RAM for the LSU: RISC-V sub-word loads/stores with fault
// reporting, valid/ready handshakes and an in-order response buffer.
module dmem_pipe #(
    parameter int          ADDR_WIDTH      = 11,
    parameter int          READ_LATENCY    = 1,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = READ_LATENCY + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  resp_err_code
);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int STAGES = READ_LATENCY - 1;
    localparam int PW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW     = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  code;
    } resp_t;

    logic [31:0]           mem [DEPTH];
    logic                  acc, pop, push_vld;
    resp_t                 acc_dat, push_dat, head;
    logic [CW-1:0]         outstanding, cnt;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    resp_t                 fifo [MAX_OUTSTANDING];

    logic [ADDR_WIDTH-1:0] widx;
    logic [1:0]            off;
    logic [31:0]           rword, wsh, lsh, ldata;
    logic [3:0]            be;
    logic                  illegal, oor, misal;
    logic [1:0]            code;

    assign req_ready = rst && (outstanding < CW'(MAX_OUTSTANDING));
    assign acc       = req_valid && req_ready;
    assign widx      = req_addr[ADDR_WIDTH+1:2];
    assign off       = req_addr[1:0];
    assign rword     = mem[widx];

    always_comb begin
        illegal = (req_load == req_store);
        if (req_load && (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11)) illegal = 1'b1;
        if (req_store && (req_funct3[2] || req_funct3[1:0] == 2'b11)) illegal = 1'b1;
        oor   = req_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2];
        misal = (req_funct3[1:0] == 2'b01 && off[0]) ||
                (req_funct3[1:0] == 2'b10 && off != 2'b00);
        code  = illegal ? 2'b11 : oor ? 2'b10 : misal ? 2'b01 : 2'b00;

        case (req_funct3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        wsh = req_wdata << {off, 3'b000};
        lsh = rword >> {off, 3'b000};

        case (req_funct3)
            3'b000:  ldata = {{24{lsh[7]}}, lsh[7:0]};
            3'b001:  ldata = {{16{lsh[15]}}, lsh[15:0]};
            3'b100:  ldata = {24'h0, lsh[7:0]};
            3'b101:  ldata = {16'h0, lsh[15:0]};
            default: ldata = lsh;
        endcase

        acc_dat.rdata = (req_load && code == 2'b00) ? ldata : 32'h0;
        acc_dat.code  = code;
    end

    // Loads read combinationally before this edge's write; one request per edge
    // means every earlier store is already in the array.
    always_ff @(posedge clk) begin
        if (acc && req_store && code == 2'b00) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][8*b +: 8] <= wsh[8*b +: 8];
        end
    end

    generate
        if (STAGES == 0) begin : g_direct
            assign push_vld = acc;
            assign push_dat = acc_dat;
        end else begin : g_pipe
            logic [STAGES:1] vld_pipe;
            resp_t           dat_pipe [1:STAGES];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) vld_pipe <= '0;
                else      vld_pipe <= {vld_pipe[STAGES:1], acc} >> 0;
            end

            always_ff @(posedge clk) begin
                dat_pipe[1] <= acc_dat;
                for (int i = 2; i <= STAGES; i++) dat_pipe[i] <= dat_pipe[i-1];
            end

            assign push_vld = vld_pipe[STAGES];
            assign push_dat = dat_pipe[STAGES];
        end
    endgenerate

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign resp_valid = (cnt != '0);
    assign pop        = resp_valid && resp_ready;
    assign head       = fifo[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_vld) fifo[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            outstanding <= '0;
        end else begin
            if (push_vld) wr_ptr <= nxt(wr_ptr);
            if (pop)      rd_ptr <= nxt(rd_ptr);
            case ({push_vld, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            case ({acc, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Gate on valid so the outputs read zero in reset and when idle.
    assign resp_rdata    = resp_valid ? head.rdata : 32'h0;
    assign resp_err_code = resp_valid ? head.code : 2'b00;
    assign resp_err      = resp_valid && (head.code != 2'b00);
endmodule
